// File: rtl/sa_feed_sched.sv
// sa_feed_sched: loads one systolic-array edge from a vector stream
// through per-row FIFOs, reading them out in a skewed diagonal wavefront.
module sa_feed_sched #(
    parameter int LANES = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LANES-1:0] fifo_we,
    input  logic [LANES-1:0] fifo_ff,
    input  logic [LANES-1:0] fifo_rv,
    output logic [LANES-1:0] fifo_re,
    output logic             fifo_is,
    input  logic             stall,
    output logic [LANES-1:0] lane_valid,
    output logic             busy,
    output logic             done
);

    localparam int TW = LEN_W + 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] wr_cnt;
    logic [TW-1:0]    tick;
    logic [TW-1:0]    len_x;
    logic [TW-1:0]    last;
    logic [LANES-1:0] active;
    logic             run;
    logic             accept;
    logic             advance;
    logic             rd_done;

    // last is the saturated tick value, one past the final advance
    assign len_x = TW'(len_q);
    assign last  = len_x + TW'(LANES - 1);
    assign run   = (state == RUN);

    // lane i reads during ticks i .. len_q+i-1, giving the diagonal skew
    always_comb begin
        active = '0;
        for (int i = 0; i < LANES; i++) begin
            active[i] = (tick >= TW'(i)) && (tick < len_x + TW'(i));
        end
    end

    // every active lane must have data; one missing lane holds all lanes
    assign advance = run & ~stall & (tick < last) & (&(fifo_rv | ~active));
    assign fifo_re = {LANES{advance}} & active;
    assign fifo_is = stall & run;

    assign in_ready = run & (wr_cnt != len_q) & ~|fifo_ff;
    assign accept   = in_valid & in_ready;
    assign fifo_we  = {LANES{accept}};

    assign rd_done = (tick == last) | (advance & (tick == last - TW'(1)));

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state: a zero-length job goes straight to FIN without FIFO traffic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (rd_done && (wr_cnt == len_q)) begin
                    state_nx = FIN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // job length, write/read counters and the delayed read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            wr_cnt     <= '0;
            tick       <= '0;
            lane_valid <= '0;
        end else begin
            lane_valid <= fifo_re;
            if ((state == IDLE) && start) begin
                len_q  <= len;
                wr_cnt <= '0;
                tick   <= '0;
            end else begin
                if (accept) begin
                    wr_cnt <= wr_cnt + LEN_W'(1);
                end
                if (advance) begin
                    tick <= tick + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_feed_sched.sv
// tb_sa_feed_sched: directed jobs against behavioural 3-deep lane FIFOs,
// with a queue of expected read-enable patterns popped on each advance.
module tb_sa_feed_sched;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   len = '0;
    logic         in_valid = 1'b0;
    logic         stall = 1'b0;
    logic         in_ready;
    logic         fifo_is;
    logic         busy;
    logic         done;
    logic [L-1:0] fifo_we;
    logic [L-1:0] fifo_ff;
    logic [L-1:0] fifo_rv;
    logic [L-1:0] fifo_re;
    logic [L-1:0] lane_valid;
    logic [L-1:0] ff_force = '0;
    logic [L-1:0] rv_mask = '0;

    int           cnt [L];
    int           total = 0;
    int           bad = 0;
    int           adv;
    int           acc;
    int           dones;
    logic [L-1:0] lv_exp = '0;
    logic [L-1:0] exp_q [$];

    logic         ir_s;
    logic         is_s;
    logic         busy_s;
    logic         done_s;
    logic [L-1:0] re_s;

    always #5 clk = ~clk;

    sa_feed_sched #(
        .LANES(L),
        .LEN_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fifo_we   (fifo_we),
        .fifo_ff   (fifo_ff),
        .fifo_rv   (fifo_rv),
        .fifo_re   (fifo_re),
        .fifo_is   (fifo_is),
        .stall     (stall),
        .lane_valid(lane_valid),
        .busy      (busy),
        .done      (done)
    );

    // behavioural FIFO status, with overrides for directed corner cases
    always_comb begin
        fifo_ff = '0;
        fifo_rv = '0;
        for (int i = 0; i < L; i++) begin
            fifo_ff[i] = (cnt[i] >= 3) | ff_force[i];
            fifo_rv[i] = (cnt[i] != 0) & ~rv_mask[i];
        end
    end

    // FIFO occupancy, flushed by the shared reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) cnt[i] <= 0;
        end else begin
            for (int i = 0; i < L; i++) begin
                cnt[i] <= cnt[i] + int'(fifo_we[i]) - int'(fifo_re[i]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [L-1:0] e;
        @(negedge clk);
        ir_s   = in_ready;
        is_s   = fifo_is;
        busy_s = busy;
        done_s = done;
        re_s   = fifo_re;
        chk("lane_valid", lane_valid, lv_exp);
        if (in_valid && in_ready) begin
            chk("we_on", fifo_we, 4'hF);
            acc++;
        end else begin
            chk("we_off", fifo_we, 0);
        end
        if (fifo_re != '0) begin
            if (exp_q.size() == 0) begin
                chk("re_extra", fifo_re, 0);
                lv_exp = '0;
            end else begin
                e = exp_q.pop_front();
                chk("re_pat", fifo_re, e);
                adv++;
                lv_exp = e;
            end
        end else begin
            lv_exp = '0;
        end
        if (done) dones++;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", fifo_we, 0);
        chk("rst_re", fifo_re, 0);
        chk("rst_is", fifo_is, 0);
        chk("rst_lane_valid", lane_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    task automatic push_pat(input logic [7:0] l);
        exp_q.delete();
        if (l == 8'd3) exp_q = {4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
        if (l == 8'd2) exp_q = {4'h1, 4'h3, 4'h6, 4'hC, 4'h8};
    endtask

    // mode: 0 plain, 1 stray start, 2 ff hold, 3 stall, 4 rv gap, 6 reset
    task automatic run_job(input logic [7:0] l, input int mode);
        int n;
        bit f;
        bit aborted;
        push_pat(l);
        adv = 0;
        acc = 0;
        dones = 0;
        f = 1'b0;
        aborted = 1'b0;
        n = 0;
        len = l;
        start = 1'b1;
        in_valid = 1'b1;
        step();
        chk("idle_busy", busy_s, 0);
        start = 1'b0;
        while (dones == 0 && n < 80) begin
            n++;
            if (mode == 1 && !f && adv == 2) begin
                f = 1'b1;
                start = 1'b1;
                len = 8'd5;
                step();
                start = 1'b0;
                chk("run_busy", busy_s, 1);
            end else if (mode == 2 && !f && acc == 1) begin
                f = 1'b1;
                ff_force = 4'b0100;
                repeat (2) begin
                    step();
                    chk("ff_in_ready", ir_s, 0);
                    chk("ff_acc", acc, 1);
                end
                ff_force = '0;
            end else if (mode == 3 && !f && adv == 2) begin
                f = 1'b1;
                stall = 1'b1;
                repeat (2) begin
                    step();
                    chk("stall_re", re_s, 0);
                    chk("stall_is", is_s, 1);
                end
                stall = 1'b0;
            end else if (mode == 4 && !f && adv == 1) begin
                f = 1'b1;
                rv_mask = 4'b0010;
                repeat (2) begin
                    step();
                    chk("rvgap_re", re_s, 0);
                end
                rv_mask = '0;
            end else if (mode == 6 && adv == 3) begin
                rst_n = 1'b0;
                #1;
                rst_chk();
                chk("rst_no_done", dones, 0);
                aborted = 1'b1;
                break;
            end else begin
                step();
            end
        end
        if (!aborted) begin
            chk("done_seen", dones, 1);
            chk("done_fin", done_s, 1);
            in_valid = 1'b0;
            step();
            chk("post_busy", busy_s, 0);
            chk("post_done", done_s, 0);
            chk("single_done", dones, 1);
            chk("accepts", acc, l);
            chk("q_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        #2;
        rst_chk();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_job(8'd3, 1);
        run_job(8'd3, 2);
        run_job(8'd3, 3);
        run_job(8'd3, 4);

        adv = 0;
        acc = 0;
        dones = 0;
        exp_q.delete();
        len = 8'd0;
        start = 1'b1;
        in_valid = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("len0_busy", busy_s, 1);
        chk("len0_done", done_s, 1);
        chk("len0_ready", ir_s, 0);
        chk("len0_re", re_s, 0);
        step();
        chk("len0_idle", busy_s, 0);
        chk("len0_dones", dones, 1);
        chk("len0_acc", acc, 0);
        in_valid = 1'b0;

        run_job(8'd3, 6);
        in_valid = 1'b0;
        stall = 1'b0;
        rv_mask = '0;
        ff_force = '0;
        exp_q.delete();
        lv_exp = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("rst_idle", busy_s, 0);
        run_job(8'd2, 0);
        chk("len2_adv", adv, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
